// File: rtl/bpsk_demod_4.sv
// bpsk_demod_4: coherent BPSK demodulator for a 4-samples-per-carrier-period
// stream. Correlates accepted samples against the reference {0,+1,0,-1},
// integrates CYCLES_PER_BIT carrier periods per symbol and emits one hard
// decision per symbol with a carrier-loss flag.
// Optional feature macro: BPSK_DIFF_DECODE_EN (differential bit decoding).
module bpsk_demod_4 #(
  parameter int unsigned CYCLES_PER_BIT = 8,
  parameter int unsigned ACC_W          = 24,
  parameter int unsigned THRESH         = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [15:0]      sample_in,
  input  logic             sample_rdy,
  input  logic             bit_sync,
  output logic             bit_out,
  output logic             bit_rdy,
  output logic             carrier_lost,
  output logic [ACC_W-1:0] corr_out
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned PER_W    = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [PER_W-1:0]        LAST_PERIOD = PER_W'(CYCLES_PER_BIT - 1);
  localparam logic signed [ACC_W-1:0] THR_POS     = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THR_NEG     = -THR_POS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t                   state, state_d;
  logic signed [ACC_W-1:0]  acc, acc_d;
  logic [1:0]               phase, phase_d;
  logic [PER_W-1:0]         period, period_d;

  logic                     accept_c;
  logic                     emit_c;
  logic                     raw_c;
  logic                     lost_c;
  logic                     bit_c;
  logic signed [ACC_W-1:0]  sample_ext_c;
  logic signed [ACC_W-1:0]  acc_next_c;

  // Sample acceptance and sign extension to the accumulator width
  assign accept_c     = CE & sample_rdy;
  assign sample_ext_c = {{(ACC_W-SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};

  // Reference correlation: +x on phase 1, -x on phase 3, nothing otherwise
  always_comb begin
    acc_next_c = acc;
    unique case (phase)
      2'd1:    acc_next_c = acc + sample_ext_c;
      2'd3:    acc_next_c = acc - sample_ext_c;
      default: acc_next_c = acc;
    endcase
  end

  // State register and symbol datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      acc    <= '0;
      phase  <= 2'd0;
      period <= '0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      phase  <= phase_d;
      period <= period_d;
    end
  end

  // Next-state logic; bit_sync restarts alignment ahead of normal advance
  always_comb begin
    state_d  = state;
    acc_d    = acc;
    phase_d  = phase;
    period_d = period;
    emit_c   = 1'b0;
    unique case (state)
      IDLE: begin
        // The sample that wakes us up is phase 0 and contributes nothing
        if (bit_sync || accept_c) begin
          state_d  = INTEG;
          acc_d    = '0;
          period_d = '0;
          phase_d  = accept_c ? 2'd1 : 2'd0;
        end
      end
      INTEG: begin
        if (bit_sync) begin
          acc_d    = '0;
          period_d = '0;
          phase_d  = accept_c ? 2'd1 : 2'd0;
        end else if (accept_c) begin
          acc_d   = acc_next_c;
          phase_d = phase + 2'd1;
          if (phase == 2'd3) begin
            if (period == LAST_PERIOD) begin
              state_d  = EMIT;
              period_d = '0;
            end else begin
              period_d = period + PER_W'(1);
            end
          end
        end
      end
      EMIT: begin
        // Emission always completes; a sample here opens the next symbol
        emit_c   = 1'b1;
        state_d  = INTEG;
        acc_d    = '0;
        period_d = '0;
        phase_d  = accept_c ? 2'd1 : 2'd0;
      end
      default: begin
        state_d  = IDLE;
        acc_d    = '0;
        phase_d  = 2'd0;
        period_d = '0;
      end
    endcase
  end

  // Hard decision and carrier check on the completed symbol sum
  assign raw_c  = acc[ACC_W-1];
  assign lost_c = (acc < THR_POS) && (acc > THR_NEG);

`ifdef BPSK_DIFF_DECODE_EN
  logic prev_raw;

  // Previous raw decision; bit_sync clears it after any emission this cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_raw <= 1'b0;
    end else if (bit_sync) begin
      prev_raw <= 1'b0;
    end else if (emit_c) begin
      prev_raw <= raw_c;
    end
  end

  assign bit_c = raw_c ^ prev_raw;
`else
  assign bit_c = raw_c;
`endif

  // Registered symbol outputs, updated only on emission
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_out      <= 1'b0;
      bit_rdy      <= 1'b0;
      carrier_lost <= 1'b1;
      corr_out     <= '0;
    end else begin
      bit_rdy <= emit_c;
      if (emit_c) begin
        bit_out      <= bit_c;
        carrier_lost <= lost_c;
        corr_out     <= acc;
      end
    end
  end

endmodule

// File: tb/tb_bpsk_demod_4.sv
// tb_bpsk_demod_4: table-driven symbol stimulus with a scoreboard of expected
// emissions (value and cycle), plus hand sequences for CE gating, bit_sync
// and mid-symbol reset.
module tb_bpsk_demod_4;

  localparam int unsigned ACC_W = 24;
  localparam int          CPB   = 8;
  localparam int          NVEC  = 11;

  logic             CLK = 1'b0;
  logic             RST;
  logic             CE;
  logic [15:0]      sample_in;
  logic             sample_rdy;
  logic             bit_sync;
  logic             bit_out;
  logic             bit_rdy;
  logic             carrier_lost;
  logic [ACC_W-1:0] corr_out;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int amp;
    int junk;
    int neg;
    int corr;
    int raw;
    int lost;
  } vec_t;

  typedef struct {
    int corr;
    int bitv;
    int lost;
    int at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   rdy_prev = 0;
  vec_t tbl[NVEC];

`ifdef BPSK_DIFF_DECODE_EN
  int prev_m = 0;
`endif

  bpsk_demod_4 #(
    .CYCLES_PER_BIT(CPB),
    .ACC_W(ACC_W),
    .THRESH(1024)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .CE(CE),
    .sample_in(sample_in),
    .sample_rdy(sample_rdy),
    .bit_sync(bit_sync),
    .bit_out(bit_out),
    .bit_rdy(bit_rdy),
    .carrier_lost(carrier_lost),
    .corr_out(corr_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic clear_prev();
`ifdef BPSK_DIFF_DECODE_EN
    prev_m = 0;
`endif
  endtask

  // Expected emission: bit_rdy visible two edges after this drive point
  task automatic push(input vec_t v);
    exp_t e;
`ifdef BPSK_DIFF_DECODE_EN
    e.bitv = v.raw ^ prev_m;
    prev_m = v.raw;
`else
    e.bitv = v.raw;
`endif
    e.corr = v.corr;
    e.lost = v.lost;
    e.at   = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic step(input int s, input logic rdy, input logic ce, input logic sync);
    @(negedge CLK);
    sample_in  = 16'(s);
    sample_rdy = rdy;
    CE         = ce;
    bit_sync   = sync;
  endtask

  function automatic int sample_of(input vec_t v, input int k);
    int ph;
    ph = k % 4;
    if (ph == 0 || ph == 2) return v.junk;
    if (ph == 1) return (v.neg != 0) ? -v.amp : v.amp;
    return (v.neg != 0) ? v.amp : -v.amp;
  endfunction

  task automatic send_symbol(input vec_t v, input bit gated, input bit sync_first);
    if (sync_first) clear_prev();
    for (int k = 0; k < 4 * CPB; k++) begin
      step(sample_of(v, k), 1'b1, 1'b1, sync_first && (k == 0));
      if (k == 4 * CPB - 1) push(v);
      if (gated) step(12345, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic partial(input vec_t v, input int n);
    for (int k = 0; k < n; k++) step(sample_of(v, k), 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bit_rdy"}, int'(bit_rdy), 0);
    chk({tag, "_carrier_lost"}, int'(carrier_lost), 1);
    chk({tag, "_corr_out"}, int'($signed(corr_out)), 0);
    chk({tag, "_bit_out"}, int'(bit_out), 0);
  endtask

  // Scoreboard monitor: every bit_rdy pops one expected emission
  always @(negedge CLK) begin
    if (bit_rdy === 1'b1) begin
      chk("bit_rdy_width", rdy_prev, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bit_rdy: got corr %0d with no symbol expected (cycle %0d)",
                 int'($signed(corr_out)), cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("corr_out", int'($signed(corr_out)), mon_e.corr);
        chk("bit_out", int'(bit_out), mon_e.bitv);
        chk("carrier_lost", int'(carrier_lost), mon_e.lost);
        chk("bit_rdy_cycle", cyc, mon_e.at);
      end
    end
    rdy_prev = int'(bit_rdy);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    //           amp    junk  neg  corr     raw lost
    tbl[0]  = '{16383,    0,  0,  262128,  0,  0};
    tbl[1]  = '{16383,    0,  1, -262128,  1,  0};
    tbl[2]  = '{16383,    0,  0,  262128,  0,  0};
    tbl[3]  = '{16383,    0,  1, -262128,  1,  0};
    tbl[4]  = '{    0,    0,  0,       0,  0,  1};
    tbl[5]  = '{   32,    0,  0,     512,  0,  1};
    tbl[6]  = '{   32,    0,  1,    -512,  1,  1};
    tbl[7]  = '{   64,    0,  0,    1024,  0,  0};
    tbl[8]  = '{   64,    0,  1,   -1024,  1,  0};
    tbl[9]  = '{   63,    0,  1,   -1008,  1,  1};
    tbl[10] = '{ 1000, 7000,  0,   16000,  0,  0};

    // Reset for two edges while a sample is offered; it must be ignored
    RST        = 1'b1;
    CE         = 1'b1;
    sample_rdy = 1'b1;
    sample_in  = 16'd16383;
    bit_sync   = 1'b1;
    repeat (2) @(negedge CLK);
    RST        = 1'b0;
    sample_rdy = 1'b0;
    bit_sync   = 1'b0;
    sample_in  = '0;
    chk_reset_vals("reset");
    idle(3);
    chk_reset_vals("reset_hold");

    // Back-to-back symbols: each symbol's first sample lands in EMIT
    for (int i = 0; i < NVEC; i++) send_symbol(tbl[i], 1'b0, 1'b0);

    // CE toggling: rejected samples must not disturb the sum
    send_symbol(tbl[0], 1'b1, 1'b0);
    send_symbol(tbl[0], 1'b1, 1'b0);

    // bit_sync after 17 samples discards the partial symbol
    partial(tbl[1], 17);
    send_symbol(tbl[0], 1'b0, 1'b1);

    // bit_sync during EMIT: emission completes, next symbol starts clean
    send_symbol(tbl[1], 1'b0, 1'b0);
    send_symbol(tbl[0], 1'b0, 1'b1);
    idle(4);

    // Reset mid-symbol overrides bit_sync and the sample on that edge
    partial(tbl[3], 20);
    @(negedge CLK);
    RST        = 1'b1;
    bit_sync   = 1'b1;
    sample_rdy = 1'b1;
    CE         = 1'b1;
    sample_in  = 16'd16383;
    @(negedge CLK);
    RST        = 1'b0;
    bit_sync   = 1'b0;
    sample_rdy = 1'b0;
    sample_in  = '0;
    clear_prev();
    chk_reset_vals("mid_reset");
    send_symbol(tbl[0], 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 200 && sb.size() != 0; i++) idle(1);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected emissions never arrived", sb.size());
    end

    // Outputs hold after the last emission
    idle(5);
    chk("hold_corr_out", int'($signed(corr_out)), 262128);
    chk("hold_carrier_lost", int'(carrier_lost), 0);
    chk("hold_bit_rdy", int'(bit_rdy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
